// File: rtl/filtro_rebote_multi_pkg.sv
// Shared definitions for the multi-channel push-button debouncer:
// repeat FSM encoding and a counter width helper.
package filtro_rebote_multi_pkg;

   typedef enum logic [1:0] {
      REP_IDLE  = 2'd0,
      REP_DELAY = 2'd1,
      REP_RATE  = 2'd2
   } rep_state_e;

   // Bits needed to hold 0..max_val, never less than one bit.
   function automatic int cnt_w(input int max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/filtro_rebote_multi_if.sv
// Button bundle between the board buttons and the debouncer: raw levels in,
// filtered level, edge pulses, repeat pulses and the shared sample tick out.
interface filtro_rebote_multi_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] iPushBtn;
   logic [NUM_CH-1:0] oPushBtn;
   logic [NUM_CH-1:0] oPress;
   logic [NUM_CH-1:0] oRelease;
   logic [NUM_CH-1:0] oRepeat;
   logic              oTick;

   modport master (
      output iPushBtn,
      input  oPushBtn, oPress, oRelease, oRepeat, oTick
   );

   modport slave (
      input  iPushBtn,
      output oPushBtn, oPress, oRelease, oRepeat, oTick
   );
endinterface

// File: rtl/filtro_rebote_canal.sv
// One debounced button channel: 2-flop synchroniser, DEPTH-sample history,
// filtered level with press/release pulses and an optional hold-to-repeat FSM.
module filtro_rebote_canal
   import filtro_rebote_multi_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DELAY = 20,
   parameter int REPEAT_RATE  = 5
) (
   input  logic Clock,
   input  logic Reset,
   input  logic tick_i,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   logic             sync1_q, sync2_q;
   logic [DEPTH-1:0] hist_q, hist_d;
   logic             level_q, level_d;
   logic             press_q, release_q;
   logic             rise, fall;

   always_comb begin
      hist_d = hist_q;
      if (tick_i) hist_d = {hist_q[DEPTH-2:0], sync2_q};
      // A mixed history keeps whatever level was last established.
      level_d = level_q;
      if (&hist_q)       level_d = 1'b1;
      else if (~|hist_q) level_d = 1'b0;
   end

   assign rise = level_d & ~level_q;
   assign fall = ~level_d & level_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         hist_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         hist_q    <= hist_d;
         level_q   <= level_d;
         press_q   <= rise;
         release_q <= fall;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

   generate
      if (REPEAT_EN != 0) begin : g_rep
         localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
         localparam int RW   = cnt_w(RMAX);

         rep_state_e    state_q;
         logic [RW-1:0] rcnt_q, rcnt_inc;
         logic          rep_q;
         logic          tick_p1_q;

         assign rcnt_inc = rcnt_q + RW'(1);

         // Ticks are counted one cycle late so they line up with level changes,
         // keeping repeat pulses a whole number of tick periods after the press.
         always_ff @(posedge Clock) begin
            if (Reset) begin
               state_q   <= REP_IDLE;
               rcnt_q    <= '0;
               rep_q     <= 1'b0;
               tick_p1_q <= 1'b0;
            end else begin
               tick_p1_q <= tick_i;
               rep_q     <= 1'b0;
               if (fall) begin
                  state_q <= REP_IDLE;
                  rcnt_q  <= '0;
               end else begin
                  case (state_q)
                     REP_IDLE: begin
                        if (rise) begin
                           state_q <= REP_DELAY;
                           rcnt_q  <= '0;
                        end
                     end
                     REP_DELAY: begin
                        if (tick_p1_q) begin
                           if (rcnt_inc == RW'(REPEAT_DELAY)) begin
                              rep_q   <= 1'b1;
                              rcnt_q  <= '0;
                              state_q <= REP_RATE;
                           end else begin
                              rcnt_q <= rcnt_inc;
                           end
                        end
                     end
                     REP_RATE: begin
                        if (tick_p1_q) begin
                           if (rcnt_inc == RW'(REPEAT_RATE)) begin
                              rep_q  <= 1'b1;
                              rcnt_q <= '0;
                           end else begin
                              rcnt_q <= rcnt_inc;
                           end
                        end
                     end
                     default: begin
                        state_q <= REP_IDLE;
                        rcnt_q  <= '0;
                     end
                  endcase
               end
            end
         end

         assign repeat_o = rep_q;
      end else begin : g_norep
         assign repeat_o = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/filtro_rebote_multi.sv
// N-channel push-button debouncer: one shared sample-tick divider feeding
// independent per-channel filters.
module filtro_rebote_multi
   import filtro_rebote_multi_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int TICK_DIV     = 3000000,
   parameter int DEPTH        = 4,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DELAY = 20,
   parameter int REPEAT_RATE  = 5
) (
   input  logic                  Clock,
   input  logic                  Reset,
   filtro_rebote_multi_if.slave  bus
);

   localparam int TW = cnt_w(TICK_DIV - 1);

   logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
   logic              wrap, tick;
   logic [NUM_CH-1:0] level_v, press_v, release_v, repeat_v;

   assign wrap       = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign tick_cnt_d = wrap ? '0 : tick_cnt_q + TW'(1);
   // Gated so a held reset forces the tick output low even when TICK_DIV is 1.
   assign tick       = wrap & ~Reset;

   always_ff @(posedge Clock) begin
      if (Reset) tick_cnt_q <= '0;
      else       tick_cnt_q <= tick_cnt_d;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      filtro_rebote_canal #(
         .DEPTH        (DEPTH),
         .REPEAT_EN    (REPEAT_EN),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_canal (
         .Clock     (Clock),
         .Reset     (Reset),
         .tick_i    (tick),
         .btn_i     (bus.iPushBtn[g]),
         .level_o   (level_v[g]),
         .press_o   (press_v[g]),
         .release_o (release_v[g]),
         .repeat_o  (repeat_v[g])
      );
   end

   assign bus.oPushBtn = level_v;
   assign bus.oPress   = press_v;
   assign bus.oRelease = release_v;
   assign bus.oRepeat  = repeat_v;
   assign bus.oTick    = tick;

endmodule

// File: tb/tb_filtro_rebote_multi.sv
// Directed bench for filtro_rebote_multi: three instances (repeat on, repeat off,
// TICK_DIV=1) exercised by one scenario task per feature.
module tb_filtro_rebote_multi;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   filtro_rebote_multi_if #(.NUM_CH(4)) ifa (), ifb (), ifc ();
   assign ifb.iPushBtn = ifa.iPushBtn;

   filtro_rebote_multi #(.NUM_CH(4), .TICK_DIV(4), .DEPTH(4), .REPEAT_EN(1),
      .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut_a (.Clock(Clock), .Reset(Reset), .bus(ifa.slave));
   filtro_rebote_multi #(.NUM_CH(4), .TICK_DIV(4), .DEPTH(4), .REPEAT_EN(0),
      .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut_b (.Clock(Clock), .Reset(Reset), .bus(ifb.slave));
   filtro_rebote_multi #(.NUM_CH(4), .TICK_DIV(1), .DEPTH(4), .REPEAT_EN(1),
      .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut_c (.Clock(Clock), .Reset(Reset), .bus(ifc.slave));

   int vecs = 0;
   int errs = 0;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      logic [16:0] oa, ob, oc;
      int ticks;
      Reset = 1'b1;
      ifa.iPushBtn = 4'hF;
      ifc.iPushBtn = 4'hF;
      repeat (4) step();
      oa = {ifa.oPushBtn, ifa.oPress, ifa.oRelease, ifa.oRepeat, ifa.oTick};
      ob = {ifb.oPushBtn, ifb.oPress, ifb.oRelease, ifb.oRepeat, ifb.oTick};
      oc = {ifc.oPushBtn, ifc.oPress, ifc.oRelease, ifc.oRepeat, ifc.oTick};
      vecs++; if (oa !== 17'h0) begin errs++; $display("FAIL reset_hold_a: got %h want 0", oa); end
      vecs++; if (ob !== 17'h0) begin errs++; $display("FAIL reset_hold_b: got %h want 0", ob); end
      vecs++; if (oc !== 17'h0) begin errs++; $display("FAIL reset_hold_c: got %h want 0", oc); end
      ifa.iPushBtn = 4'h0;
      ifc.iPushBtn = 4'h0;
      step();
      Reset = 1'b0;
      #1;
      vecs++; if (ifa.oTick !== 1'b0) begin errs++; $display("FAIL tick_a_after_reset: got %b want 0", ifa.oTick); end
      vecs++; if (ifc.oTick !== 1'b1) begin errs++; $display("FAIL tick_c_after_reset: got %b want 1", ifc.oTick); end
      ticks = 0;
      for (int n = 0; n < 16; n++) begin
         step();
         if (ifa.oTick === 1'b1) ticks++;
      end
      vecs++; if (ticks !== 4) begin errs++; $display("FAIL tick_a_period: got %0d ticks want 4", ticks); end
      repeat (10) step();
   endtask

   task automatic test_clean_press();
      int rise_c, press_c, npress, others;
      rise_c = -1; press_c = -1; npress = 0; others = 0;
      ifa.iPushBtn[0] = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (ifa.oPushBtn[0] === 1'b1 && rise_c < 0) rise_c = n;
         if (ifa.oPress[0] === 1'b1) begin npress++; if (press_c < 0) press_c = n; end
         if (ifa.oPushBtn[3:1] !== 3'b0 || ifa.oPress[3:1] !== 3'b0) others++;
      end
      vecs++; if (rise_c < 15 || rise_c > 19) begin errs++; $display("FAIL press_latency: got %0d want 15..19", rise_c); end
      vecs++; if (npress !== 1) begin errs++; $display("FAIL press_count: got %0d want 1", npress); end
      vecs++; if (press_c !== rise_c) begin errs++; $display("FAIL press_align: got %0d want %0d", press_c, rise_c); end
      vecs++; if (others !== 0) begin errs++; $display("FAIL press_other_ch: got %0d active cycles want 0", others); end
   endtask

   task automatic test_release();
      int fall_c, rel_c, nrel, rep_at_rel, both;
      fall_c = -1; rel_c = -1; nrel = 0; rep_at_rel = 0; both = 0;
      ifa.iPushBtn[0] = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (ifa.oPushBtn[0] === 1'b0 && fall_c < 0) fall_c = n;
         if (ifa.oRelease[0] === 1'b1) begin
            nrel++;
            if (rel_c < 0) rel_c = n;
            if (ifa.oRepeat[0] !== 1'b0) rep_at_rel++;
            if (ifa.oPress[0] !== 1'b0) both++;
         end
      end
      vecs++; if (fall_c < 15 || fall_c > 19) begin errs++; $display("FAIL release_latency: got %0d want 15..19", fall_c); end
      vecs++; if (nrel !== 1) begin errs++; $display("FAIL release_count: got %0d want 1", nrel); end
      vecs++; if (rel_c !== fall_c) begin errs++; $display("FAIL release_align: got %0d want %0d", rel_c, fall_c); end
      vecs++; if (rep_at_rel + both !== 0) begin errs++; $display("FAIL release_exclusive: got %0d overlaps want 0", rep_at_rel + both); end
   endtask

   task automatic test_bounce();
      logic [2:0] pat;
      int bounce_press, npress, press_c, found;
      pat = 3'b101;
      bounce_press = 0; npress = 0; press_c = -1; found = 0;
      for (int n = 0; n < 8 && found == 0; n++) begin
         step();
         if (ifa.oTick === 1'b1) found = 1;
      end
      vecs++; if (found !== 1) begin errs++; $display("FAIL bounce_tick_sync: got %0d want 1", found); end
      for (int k = 0; k < 3; k++) begin
         ifa.iPushBtn[1] = pat[k];
         repeat (4) begin
            step();
            if (ifa.oPress[1] !== 1'b0 || ifa.oPushBtn[1] !== 1'b0) bounce_press++;
         end
      end
      ifa.iPushBtn[1] = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (ifa.oPress[1] === 1'b1) begin npress++; if (press_c < 0) press_c = n; end
      end
      vecs++; if (bounce_press !== 0) begin errs++; $display("FAIL bounce_quiet: got %0d active cycles want 0", bounce_press); end
      vecs++; if (npress !== 1) begin errs++; $display("FAIL bounce_press_count: got %0d want 1", npress); end
      vecs++; if (press_c !== 14) begin errs++; $display("FAIL bounce_press_time: got %0d want 14", press_c); end
      ifa.iPushBtn[1] = 1'b0;
      repeat (25) step();
      vecs++; if (ifa.oPushBtn[1] !== 1'b0) begin errs++; $display("FAIL bounce_release_level: got %b want 0", ifa.oPushBtn[1]); end
   endtask

   task automatic test_repeat();
      int pc, nrep, coinc, b_rep, b_press;
      int rep_off [3];
      pc = -1; nrep = 0; coinc = 0; b_rep = 0; b_press = 0;
      for (int i = 0; i < 3; i++) rep_off[i] = -1;
      ifa.iPushBtn[2] = 1'b1;
      for (int n = 1; n <= 70; n++) begin
         step();
         if (ifa.oPress[2] === 1'b1 && pc < 0) pc = n;
         if (ifa.oRepeat[2] === 1'b1) begin
            if (nrep < 3 && pc >= 0) rep_off[nrep] = n - pc;
            nrep++;
            if (ifa.oPress[2] !== 1'b0) coinc++;
         end
         if (ifb.oRepeat !== 4'b0) b_rep++;
         if (ifb.oPress[2] === 1'b1) b_press++;
      end
      vecs++; if (pc < 15 || pc > 19) begin errs++; $display("FAIL repeat_press_latency: got %0d want 15..19", pc); end
      vecs++; if (rep_off[0] !== 12) begin errs++; $display("FAIL repeat_first: got %0d want 12", rep_off[0]); end
      vecs++; if (rep_off[1] !== 20) begin errs++; $display("FAIL repeat_second: got %0d want 20", rep_off[1]); end
      vecs++; if (rep_off[2] !== 28) begin errs++; $display("FAIL repeat_third: got %0d want 28", rep_off[2]); end
      vecs++; if (coinc !== 0) begin errs++; $display("FAIL repeat_vs_press: got %0d overlaps want 0", coinc); end
      vecs++; if (b_press !== 1) begin errs++; $display("FAIL norep_press_count: got %0d want 1", b_press); end
      vecs++; if (b_rep !== 0) begin errs++; $display("FAIL norep_repeat: got %0d active cycles want 0", b_rep); end
   endtask

   task automatic test_reset_mid_hold();
      logic [16:0] oa;
      int pc;
      pc = -1;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      #1;
      oa = {ifa.oPushBtn, ifa.oPress, ifa.oRelease, ifa.oRepeat, ifa.oTick};
      vecs++; if (oa !== 17'h0) begin errs++; $display("FAIL midhold_reset_outputs: got %h want 0", oa); end
      for (int n = 1; n <= 30; n++) begin
         step();
         if (ifa.oPress[2] === 1'b1 && pc < 0) pc = n;
      end
      vecs++; if (pc < 15 || pc > 19) begin errs++; $display("FAIL midhold_repress: got %0d want 15..19", pc); end
      ifa.iPushBtn[2] = 1'b0;
      repeat (30) step();
   endtask

   task automatic test_multi_tick1();
      int lat, tick_bad, npress_cyc;
      logic [3:0] press_v, level_v;
      lat = -1; tick_bad = 0; npress_cyc = 0; press_v = 4'h0; level_v = 4'h0;
      ifc.iPushBtn = 4'hF;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (ifc.oTick !== 1'b1) tick_bad++;
         if (ifc.oPress !== 4'h0) begin
            npress_cyc++;
            if (lat < 0) begin lat = n; press_v = ifc.oPress; level_v = ifc.oPushBtn; end
         end
      end
      vecs++; if (lat < 6 || lat > 7) begin errs++; $display("FAIL multi_latency: got %0d want 6..7", lat); end
      vecs++; if (press_v !== 4'hF) begin errs++; $display("FAIL multi_press: got %h want f", press_v); end
      vecs++; if (level_v !== 4'hF) begin errs++; $display("FAIL multi_level: got %h want f", level_v); end
      vecs++; if (npress_cyc !== 1) begin errs++; $display("FAIL multi_press_width: got %0d want 1", npress_cyc); end
      vecs++; if (tick_bad !== 0) begin errs++; $display("FAIL tick1_every_cycle: got %0d gaps want 0", tick_bad); end
   endtask

   initial begin
      ifa.iPushBtn = 4'h0;
      ifc.iPushBtn = 4'h0;
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_repeat();
      test_reset_mid_hold();
      test_multi_tick1();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/filtro_rebote_multi.md
Name: filtro_rebote_multi

Overview:
- Parametrised N-channel push-button debouncer with input synchronisation, a shared sample tick and an N-deep stability filter per channel.
- Adds one-cycle press/release pulses and optional hold-to-repeat pulses.
- Sits between board push-buttons and the control FSMs; replaces the fixed 4-channel, 4-sample debouncer.

Parameters:
- NUM_CH, 4, number of independent button channels.
- TICK_DIV, 3000000, sample period in Clock cycles (≥1); shared tick counter runs 0..TICK_DIV-1.
- DEPTH, 4, consecutive equal samples required to change the filtered level (≥2).
- REPEAT_EN, 1, 1 = generate oRepeat pulses while held; 0 = oRepeat tied 0, repeat logic removed.
- REPEAT_DELAY, 20, ticks after the press pulse before the first repeat pulse (≥1).
- REPEAT_RATE, 5, ticks between subsequent repeat pulses (≥1).

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- iPushBtn  input  NUM_CH  raw asynchronous button levels.
- oPushBtn  output  NUM_CH  debounced level per channel.
- oPress  output  NUM_CH  1-cycle pulse on the filtered 0→1 transition.
- oRelease  output  NUM_CH  1-cycle pulse on the filtered 1→0 transition.
- oRepeat  output  NUM_CH  1-cycle auto-repeat pulse while held.
- oTick  output  1  1-cycle pulse when the channels sample (debug/shared timing).

Behaviour:
- Reset (synchronous, active-high) clears the tick counter, synchroniser flops, history, repeat counters and every output to 0. Holding Reset asserted keeps all outputs at 0.
- Synchroniser: 2-flop per channel. Only the synchronised value is sampled.
- Tick: the counter increments each cycle and wraps TICK_DIV-1→0. oTick=1 in the cycle the counter equals TICK_DIV-1. TICK_DIV=1 gives oTick=1 every cycle.
- History: on oTick, each channel's DEPTH-bit shift register shifts left and takes the synchronised bit at bit 0.
- Filtered level, registered from the history:
  - all-ones → oPushBtn=1.
  - all-zeros → oPushBtn=0.
  - mixed → hold the previous value.
  - The level changes one cycle after the shift that completes the run.
- Edges: oPress/oRelease assert in the same cycle oPushBtn changes, for exactly 1 cycle. They are never asserted together on one channel.
- Latency: a clean input step appears on oPushBtn within 2 + (DEPTH-1)·TICK_DIV + 1 to 2 + DEPTH·TICK_DIV + 1 cycles.
- Glitches: a glitch shorter than one tick period may or may not be sampled. A glitch covering fewer than DEPTH consecutive samples never changes the level.
- Repeat, per channel, 3-state FSM:
  - IDLE → DELAY on press; the tick counter is cleared.
  - DELAY: count ticks. When the count reaches REPEAT_DELAY, pulse oRepeat, clear the count and go to RATE.
  - RATE: when the count reaches REPEAT_RATE, pulse oRepeat and clear the count.
  - Any state → IDLE on release, same cycle; no oRepeat in that cycle.
  - oRepeat is never coincident with oPress.
- Counter widths are $clog2(max+1). Counters never wrap in an active state because they are cleared on match.
- Reset mid-operation (pulse, hold or repeat in progress) aborts immediately. A button still held after reset re-debounces from a zero history and produces a fresh oPress.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.

Decomposition:
- Shared package: repeat-state encoding (IDLE/DELAY/RATE) and a clog2-style width helper.
- Top level: tick divider plus a generate loop over channels.
- One sub-module, filtro_rebote_canal. It holds the synchroniser, history, level, edge pulses and repeat FSM. It takes the tick as input and is parametrised by DEPTH, REPEAT_EN, REPEAT_DELAY and REPEAT_RATE.

Test Plan (TICK_DIV=4, DEPTH=4, REPEAT_DELAY=3, REPEAT_RATE=2, NUM_CH=4 unless noted):
- Clean press: set iPushBtn[0] from 0 to 1 at cycle 0 and hold → oPushBtn[0]=1 and a single oPress[0] pulse between cycles 15 and 19; other channels stay 0.
- Bounce: toggle iPushBtn[1] on each of 3 consecutive ticks, then hold at 1 → no oPress during the bounce; exactly one oPress[1] after 4 stable ticks.
- Release: release channel 0 after it is stable high → oRelease[0] pulses once and oPushBtn[0] falls 15–19 cycles later; no oRepeat in that cycle.
- Auto-repeat: hold channel 2 → oPress, then the first oRepeat 12 cycles (3 ticks) later, then oRepeat every 8 cycles. With REPEAT_EN=0, oRepeat stays 0 throughout.
- Reset mid-hold: assert Reset for 1 cycle during the RATE state → all outputs 0 the next cycle. With the button still held, a new oPress appears 15–19 cycles after Reset deasserts.
- Multi-channel and TICK_DIV=1: press all 4 channels on the same cycle → 4 simultaneous oPress pulses; oTick=1 every cycle; latency is 6–7 cycles.
